// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Register address type, exception FSM states and the zero register.
package cpu_defs_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic {
        EXC_IDLE,
        EXC_HOLD
    } exc_state_e;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/hazard_slot_cmp.sv
// Single-slot load-use comparator against every E and M slot.
// $0 never hits, as source or destination.
module hazard_slot_cmp
    import cpu_defs_pkg::*;
#(
    parameter int ISSUE_NUM = 2,
    parameter int RA_W      = 5
) (
    input  logic                      valid,
    input  logic [RA_W-1:0]           rs,
    input  logic [RA_W-1:0]           rt,
    input  logic [ISSUE_NUM-1:0]      e_load,
    input  logic [ISSUE_NUM*RA_W-1:0] e_waddr,
    input  logic [ISSUE_NUM-1:0]      m_load,
    input  logic [ISSUE_NUM*RA_W-1:0] m_waddr,
    output logic                      hit
);

    localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

    logic [RA_W-1:0] ew;
    logic [RA_W-1:0] mw;
    logic            any;

    always_comb begin
        any = 1'b0;
        ew  = ZR;
        mw  = ZR;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            ew = e_waddr[k*RA_W +: RA_W];
            mw = m_waddr[k*RA_W +: RA_W];
            if (e_load[k] && (ew != ZR)) begin
                if ((rs != ZR) && (rs == ew)) any = 1'b1;
                if ((rt != ZR) && (rt == ew)) any = 1'b1;
            end
            if (m_load[k] && (mw != ZR)) begin
                if ((rs != ZR) && (rs == mw)) any = 1'b1;
                if ((rt != ZR) && (rt == mw)) any = 1'b1;
            end
        end
        hit = valid & any;
    end

endmodule

// File: rtl/hazard_ctrl_mi.sv
// N-issue hazard/stall/flush controller with a registered exception hold.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl_mi
    import cpu_defs_pkg::*;
#(
    parameter int ISSUE_NUM = 2,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_stall,
    input  logic                      d_stall,
    input  logic                      E_alu_stall,
    input  logic [ISSUE_NUM-1:0]      D_valid,
    input  logic [ISSUE_NUM*RA_W-1:0] D_rs,
    input  logic [ISSUE_NUM*RA_W-1:0] D_rt,
    input  logic [ISSUE_NUM-1:0]      E_memtoReg,
    input  logic [ISSUE_NUM*RA_W-1:0] E_reg_waddr,
    input  logic [ISSUE_NUM-1:0]      M_memtoReg,
    input  logic [ISSUE_NUM*RA_W-1:0] M_reg_waddr,
    input  logic                      D_branch_taken,
    input  logic                      M_except,
    output logic                      longest_stall,
    output logic [ISSUE_NUM-1:0]      D_issue_mask,
    output logic                      lwstall,
    output logic                      exc_pending,
    output logic                      F_ena,
    output logic                      D_ena,
    output logic                      E_ena,
    output logic                      M_ena,
    output logic                      W_ena,
    output logic                      F_flush,
    output logic                      D_flush,
    output logic                      E_flush,
    output logic                      M_flush,
    output logic                      W_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]          perf_lw_cnt,
    output logic [CNT_W-1:0]          perf_long_cnt
`endif
);

    logic [ISSUE_NUM-1:0] hit;
    logic                 blocked;
    logic                 exc_fire;
    logic                 hold_active;
    exc_state_e           state_q;
    exc_state_e           state_d;

    for (genvar s = 0; s < ISSUE_NUM; s++) begin : g_slot
        hazard_slot_cmp #(
            .ISSUE_NUM(ISSUE_NUM),
            .RA_W     (RA_W)
        ) u_cmp (
            .valid  (D_valid[s]),
            .rs     (D_rs[s*RA_W +: RA_W]),
            .rt     (D_rt[s*RA_W +: RA_W]),
            .e_load (E_memtoReg),
            .e_waddr(E_reg_waddr),
            .m_load (M_memtoReg),
            .m_waddr(M_reg_waddr),
            .hit    (hit[s])
        );
    end

    assign longest_stall = E_alu_stall | i_stall | d_stall;
    assign lwstall       = hit[0];

    // A blocked slot blocks every younger slot behind it.
    always_comb begin
        blocked      = 1'b0;
        D_issue_mask = '0;
        for (int s = 0; s < ISSUE_NUM; s++) begin
            blocked         = blocked | hit[s];
            D_issue_mask[s] = D_valid[s] & ~blocked;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EXC_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        exc_fire = 1'b0;
        unique case (state_q)
            EXC_IDLE: begin
                if (M_except) begin
                    if (longest_stall) state_d = EXC_HOLD;
                    else               exc_fire = 1'b1;
                end
            end
            EXC_HOLD: begin
                if (!longest_stall) begin
                    exc_fire = 1'b1;
                    state_d  = EXC_IDLE;
                end
            end
            default: state_d = EXC_IDLE;
        endcase
        // Reset drops a held exception without flushing.
        if (rst) exc_fire = 1'b0;
    end

    assign hold_active = (state_q == EXC_HOLD);
    assign exc_pending = hold_active;

    assign F_ena = ~i_stall;
    assign D_ena = ~(lwstall | longest_stall | hold_active);
    assign E_ena = ~longest_stall;
    assign M_ena = ~longest_stall;
    assign W_ena = ~longest_stall;

    assign F_flush = 1'b0;
    assign W_flush = 1'b0;
    assign E_flush = exc_fire;
    assign M_flush = exc_fire;
    assign D_flush = exc_fire | (D_branch_taken & ~longest_stall);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw_cnt   <= '0;
            perf_long_cnt <= '0;
        end else begin
            if (lwstall && !longest_stall && (perf_lw_cnt != '1))
                perf_lw_cnt <= perf_lw_cnt + 1'b1;
            if (longest_stall && (perf_long_cnt != '1))
                perf_long_cnt <= perf_long_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl_mi.md
Name: hazard_ctrl_mi

Overview:
- Parametrised hazard/stall/flush controller for the N-issue in-order pipeline (F, D, E, M, W).
- Successor to the fixed dual-issue hazard unit. Differences from it:
  - Checks load-use on every issue slot, not only master.
  - Ignores $0.
  - Produces a per-slot in-order issue mask.
  - Replaces the W-stage exception special case with a registered exception-hold FSM, so an exception raised during a long stall is flushed exactly when the pipeline advances.
- Sits beside the pipeline registers and drives all stage enables and flushes.

Parameters:
- ISSUE_NUM, 2, number of issue slots per stage (1..4).
- RA_W, 5, register address width.
- CNT_W, 32, perf-counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_stall  in  1  I-cache/fetch stall
- d_stall  in  1  D-cache stall
- E_alu_stall  in  1  multi-cycle ALU busy
- D_valid  in  ISSUE_NUM  per-slot valid in D
- D_rs  in  ISSUE_NUM*RA_W  per-slot rs, slot 0 in LSBs
- D_rt  in  ISSUE_NUM*RA_W  per-slot rt
- E_memtoReg  in  ISSUE_NUM  per-slot load in E
- E_reg_waddr  in  ISSUE_NUM*RA_W  per-slot dest in E
- M_memtoReg  in  ISSUE_NUM  per-slot load in M
- M_reg_waddr  in  ISSUE_NUM*RA_W  per-slot dest in M
- D_branch_taken  in  1  branch resolved taken in D
- M_except  in  1  exception in M
- longest_stall  out  1  any long stall
- D_issue_mask  out  ISSUE_NUM  slots allowed to leave D this cycle
- lwstall  out  1  slot 0 load-use stall
- exc_pending  out  1  registered: exception held during stall
- F_ena, D_ena, E_ena, M_ena, W_ena  out  1 each
- F_flush, D_flush, E_flush, M_flush, W_flush  out  1 each

Behaviour:
- longest_stall = E_alu_stall | i_stall | d_stall. Combinational.
- Per-slot hazard:
  - hit(s) = D_valid[s] and (rs or rt of slot s is nonzero) and equals any E or M slot k's waddr where that slot's memtoReg=1 and waddr!=0.
  - Source register $0 never hits.
- D_issue_mask[s] = D_valid[s] & ~hit(j) for all j<=s. Strictly in order: a blocked slot blocks all higher slots.
- lwstall = hit(0).
- Enables:
  - F_ena = ~i_stall
  - D_ena = ~(lwstall | longest_stall | exc_hold_active)
  - E_ena = M_ena = W_ena = ~longest_stall
- Flushes:
  - F_flush = W_flush = 0.
  - E_flush = M_flush = exc_fire.
  - D_flush = exc_fire | (D_branch_taken & ~longest_stall).
- Exception FSM, 2 states, reset to IDLE, exc_pending=0:
  - IDLE:
    - M_except & ~longest_stall → exc_fire=1 this cycle; stay IDLE.
    - M_except & longest_stall → HOLD next cycle; no flush yet.
  - HOLD (exc_pending=1, exc_hold_active=1):
    - M_except ignored; the latched event has priority.
    - First cycle with ~longest_stall → exc_fire=1, return to IDLE.
  - exc_fire is combinational: (IDLE & M_except & ~longest_stall) | (HOLD & ~longest_stall).
- Simultaneous events:
  - Exception flush outranks branch flush; both drive D_flush=1.
  - lwstall does not delay exc_fire.
- Boundary cases:
  - D_valid=0 slots never hit.
  - A slot matching its own bundle's E entry is still a hazard.
  - rst during HOLD → IDLE, exc_pending=0 next cycle, no flush issued.
- All outputs other than exc_pending and the counters are combinational from inputs and state. Zero latency.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_lw_cnt and perf_long_cnt, each CNT_W.
  - perf_lw_cnt increments per cycle with lwstall & ~longest_stall.
  - perf_long_cnt increments per cycle with longest_stall.
  - Both saturate at all-ones and reset to 0.
- When undefined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - reg_addr_t (RA_W bits)
  - exc_state_e {EXC_IDLE, EXC_HOLD}
  - ZERO_REG constant
- One natural sub-module: hazard_slot_cmp, the combinational single-slot load-use comparator against all E/M slots, instantiated ISSUE_NUM times.

Test Plan:
1. E slot 0 has memtoReg=1, waddr=3; D slot 0 has rs=3 → lwstall=1, D_ena=0, D_issue_mask=00, E_ena=1.
2. D slot 1 has rt=5; M slot 1 has memtoReg=1, waddr=5; slot 0 is clean → D_issue_mask=01, lwstall=0, D_ena=1.
3. D rs=0 and E load with waddr=0 → no hazard; D_issue_mask=11.
4. M_except=1 while d_stall=1 for 4 cycles:
   - no flush during the stall; exc_pending=1 from the next cycle;
   - on the cycle d_stall drops: D_flush=E_flush=M_flush=1, then exc_pending=0.
5. D_branch_taken=1 while i_stall=0 and no long stall → D_flush=1, E_flush=0. With d_stall=1 the same input gives D_flush=0.
6. rst asserted while in HOLD → exc_pending=0 next cycle, no flush. With HAZARD_PERF_EN: 10 lwstall cycles → perf_lw_cnt=10.
